// File: rtl/hex_word_streamer.sv
// rtl/hex_word_streamer.sv - serialises a word into an ASCII hex byte stream, MSB nibble first
// Optional trailing CR/LF per word when HEX_STREAM_CRLF_EN is defined.
module hex_word_streamer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [3:0]        nib_out,
  input  logic [7:0]        ascii_in,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy
);

  localparam int NIB = WORD_W / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND
`ifdef HEX_STREAM_CRLF_EN
    ,
    CR,
    LF
`endif
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [IW-1:0]     idx;
  logic              hs;

  assign hs = byte_valid & byte_ready;

  // The converter is combinational, so the nibble must come straight off the registers.
  assign nib_out = word_q[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_q     <= '0;
      idx        <= '0;
      word_ready <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          word_ready <= 1'b1;
          if (word_valid && word_ready) begin
            word_q     <= word_in;
            idx        <= IW'(NIB - 1);
            busy       <= 1'b1;
            word_ready <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          byte_out   <= ascii_in;
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (hs) begin
            byte_valid <= 1'b0;
            // Test idx before decrementing so the index never wraps.
            if (idx != '0) begin
              idx   <= idx - IW'(1);
              state <= LOAD;
            end else begin
`ifdef HEX_STREAM_CRLF_EN
              state <= CR;
`else
              busy       <= 1'b0;
              word_ready <= 1'b1;
              state      <= IDLE;
`endif
            end
          end
        end
`ifdef HEX_STREAM_CRLF_EN
        // Each terminator spends one cycle presenting, then waits for its handshake.
        CR: begin
          if (!byte_valid) begin
            byte_out   <= 8'h0D;
            byte_valid <= 1'b1;
          end else if (hs) begin
            byte_valid <= 1'b0;
            state      <= LF;
          end
        end
        LF: begin
          if (!byte_valid) begin
            byte_out   <= 8'h0A;
            byte_valid <= 1'b1;
          end else if (hs) begin
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            word_ready <= 1'b1;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_streamer.sv
// tb/tb_hex_word_streamer.sv - self-checking bench for hex_word_streamer (32-bit and 8-bit builds)
module tb_hex_word_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] w_in = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [3:0]  nib;
  logic [7:0]  ascii;
  logic [7:0]  b_out;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic        busy;

  logic [7:0]  w8_in = '0;
  logic        w8_valid = 1'b0;
  logic        w8_ready;
  logic [3:0]  nib8;
  logic [7:0]  ascii8;
  logic [7:0]  b8_out;
  logic        b8_valid;
  logic        b8_ready = 1'b1;
  logic        busy8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign ascii  = hex_ascii(nib);
  assign ascii8 = hex_ascii(nib8);

  hex_word_streamer #(.WORD_W(32)) dut (
    .clk(clk), .rst(rst), .word_in(w_in), .word_valid(w_valid), .word_ready(w_ready),
    .nib_out(nib), .ascii_in(ascii), .byte_out(b_out), .byte_valid(b_valid),
    .byte_ready(b_ready), .busy(busy)
  );

  hex_word_streamer #(.WORD_W(8)) dut8 (
    .clk(clk), .rst(rst), .word_in(w8_in), .word_valid(w8_valid), .word_ready(w8_ready),
    .nib_out(nib8), .ascii_in(ascii8), .byte_out(b8_out), .byte_valid(b8_valid),
    .byte_ready(b8_ready), .busy(busy8)
  );

  // Expected character stream: the word printed as upper-case hex, low nib digits, plus CR/LF.
  function automatic string model_str(input logic [31:0] w, input int nd);
    string s;
    s = $sformatf("%h", w);
    s = s.toupper();
    s = s.substr(8 - nd, 7);
`ifdef HEX_STREAM_CRLF_EN
    s = {s, "\015\012"};
`endif
    return s;
  endfunction

  task automatic send32(input logic [31:0] w, output int acc);
    acc = -1;
    @(negedge clk);
    w_in = w;
    w_valid = 1'b1;
    for (int c = 0; c < 60 && acc < 0; c++) begin
      if (w_ready) acc = cyc;
      else @(negedge clk);
    end
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  // Byte sink with programmable ready; also counts any change of a stalled byte.
  task automatic collect32(input int n, input int pct, output logic [7:0] got[$],
                           output int hs[$], output int stable_err);
    logic       hold;
    logic [7:0] held;
    got.delete();
    hs.delete();
    stable_err = 0;
    hold = 1'b0;
    held = '0;
    for (int c = 0; c < n * 30 + 40 && got.size() < n; c++) begin
      @(negedge clk);
      if (hold && (!b_valid || b_out !== held)) stable_err++;
      b_ready = ($urandom_range(99) < pct);
      if (b_valid && b_ready) begin
        got.push_back(b_out);
        hs.push_back(cyc);
        hold = 1'b0;
      end else begin
        hold = b_valid;
        held = b_out;
      end
    end
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL reset_word_ready: got %b expected 0", w_ready); end
    n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_byte_valid: got %b expected 0", b_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (nib !== 4'h0) begin n_bad++; $display("FAIL reset_nib_out: got %h expected 0", nib); end
    n_cmp++; if (b_out !== 8'h00) begin n_bad++; $display("FAIL reset_byte_out: got %h expected 00", b_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (w_ready !== 1'b1) begin n_bad++; $display("FAIL idle_word_ready: got %b expected 1", w_ready); end
  endtask

  task automatic test_basic();
    string e;
    logic [7:0] got[$];
    int hs[$];
    int se, acc;
    logic [7:0] ev;
    e = model_str(32'h1234ABCD, 8);
    send32(32'h1234ABCD, acc);
    collect32(e.len(), 100, got, hs, se);
    n_cmp++; if (got.size() != e.len()) begin n_bad++; $display("FAIL basic_len: got %0d expected %0d", got.size(), e.len()); end
    for (int i = 0; i < got.size() && i < e.len(); i++) begin
      ev = e[i];
      n_cmp++; if (got[i] !== ev) begin n_bad++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, got[i], ev); end
    end
    if (hs.size() > 0) begin
      n_cmp++; if (hs[0] - acc != 2) begin n_bad++; $display("FAIL basic_latency: got %0d expected 2", hs[0] - acc); end
    end
    for (int i = 1; i < hs.size(); i++) begin
      n_cmp++; if (hs[i] - hs[i-1] != 2) begin n_bad++; $display("FAIL basic_rate[%0d]: got %0d expected 2", i, hs[i] - hs[i-1]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_stall(input logic [31:0] w, input int pct);
    string e;
    logic [7:0] got[$];
    int hs[$];
    int se, acc;
    logic [7:0] ev;
    e = model_str(w, 8);
    send32(w, acc);
    n_cmp++; if (acc < 0) begin n_bad++; $display("FAIL stall_accept: got timeout expected accept"); end
    collect32(e.len(), pct, got, hs, se);
    n_cmp++; if (got.size() != e.len()) begin n_bad++; $display("FAIL stall_len: got %0d expected %0d", got.size(), e.len()); end
    for (int i = 0; i < got.size() && i < e.len(); i++) begin
      ev = e[i];
      n_cmp++; if (got[i] !== ev) begin n_bad++; $display("FAIL stall_byte[%0d]: got %h expected %h (word %h)", i, got[i], ev, w); end
    end
    n_cmp++; if (se != 0) begin n_bad++; $display("FAIL stall_hold: got %0d changes expected 0", se); end
  endtask

  task automatic test_busy_ignore();
    string e;
    logic [7:0] got[$];
    int hs[$];
    int se, acc, extra;
    logic [7:0] ev;
    e = model_str(32'h0BADF00D, 8);
    send32(32'h0BADF00D, acc);
    fork
      collect32(e.len(), 100, got, hs, se);
      begin
        repeat (5) @(negedge clk);
        w_in = 32'h12345678;
        w_valid = 1'b1;
        n_cmp++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL busy_word_ready: got %b expected 0", w_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_flag: got %b expected 1", busy); end
        @(negedge clk);
        w_valid = 1'b0;
      end
    join
    for (int i = 0; i < got.size() && i < e.len(); i++) begin
      ev = e[i];
      n_cmp++; if (got[i] !== ev) begin n_bad++; $display("FAIL busy_byte[%0d]: got %h expected %h", i, got[i], ev); end
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_valid || busy) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL busy_no_capture: got %0d active cycles expected 0", extra); end
    test_stall(32'h00C0FFEE, 100);
  endtask

  task automatic test_reset_mid();
    string e;
    logic [7:0] got[$];
    int hs[$];
    int se, acc;
    logic [31:0] w;
    logic [7:0] ev;
    w = $urandom;
    e = model_str(w, 8);
    send32(w, acc);
    collect32(3, 100, got, hs, se);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      ev = e[i];
      n_cmp++; if (got[i] !== ev) begin n_bad++; $display("FAIL rstmid_byte[%0d]: got %h expected %h", i, got[i], ev); end
    end
    @(negedge clk);
    n_cmp++; if (b_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pending: got %b expected 1", b_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_byte_valid: got %b expected 0", b_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    test_stall(32'hFFFFFFFF, 100);
  endtask

  task automatic test_back_to_back();
    string e;
    logic [7:0] got[$];
    int hs[$];
    int accq[$];
    int se, l;
    logic [7:0] ev;
    e = {model_str(32'hDEADBEEF, 8), model_str(32'h00000000, 8)};
    l = e.len() / 2;
    fork
      collect32(e.len(), 100, got, hs, se);
      begin
        int a;
        a = 0;
        @(negedge clk);
        w_in = 32'hDEADBEEF;
        w_valid = 1'b1;
        for (int c = 0; c < 400 && a < 2; c++) begin
          if (w_ready) begin
            accq.push_back(cyc);
            a++;
            @(negedge clk);
            if (a == 1) w_in = 32'h0;
            else w_valid = 1'b0;
          end else @(negedge clk);
        end
        w_valid = 1'b0;
      end
    join
    n_cmp++; if (got.size() != e.len()) begin n_bad++; $display("FAIL b2b_len: got %0d expected %0d", got.size(), e.len()); end
    for (int i = 0; i < got.size() && i < e.len(); i++) begin
      ev = e[i];
      n_cmp++; if (got[i] !== ev) begin n_bad++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, got[i], ev); end
    end
    n_cmp++; if (accq.size() != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 2", accq.size()); end
    if (accq.size() == 2 && hs.size() >= l) begin
      n_cmp++; if (accq[1] - hs[l-1] != 1) begin n_bad++; $display("FAIL b2b_idle_gap: got %0d expected 1", accq[1] - hs[l-1]); end
    end
  endtask

  task automatic test_width8();
    string e;
    logic [7:0] got[$];
    logic [7:0] ev;
    bit acc;
    e = model_str(32'h000000A5, 2);
    acc = 1'b0;
    @(negedge clk);
    w8_in = 8'hA5;
    w8_valid = 1'b1;
    for (int c = 0; c < 60 && !acc; c++) begin
      if (w8_ready) acc = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    w8_valid = 1'b0;
    for (int c = 0; c < 80 && got.size() < e.len(); c++) begin
      @(negedge clk);
      if (b8_valid) got.push_back(b8_out);
    end
    n_cmp++; if (got.size() != e.len()) begin n_bad++; $display("FAIL w8_len: got %0d expected %0d", got.size(), e.len()); end
    for (int i = 0; i < got.size() && i < e.len(); i++) begin
      ev = e[i];
      n_cmp++; if (got[i] !== ev) begin n_bad++; $display("FAIL w8_byte[%0d]: got %h expected %h", i, got[i], ev); end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL w8_busy_end: got %b expected 0", busy8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall(32'h0000000F, 30);
    for (int k = 0; k < 4; k++) test_stall($urandom, $urandom_range(20, 90));
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
